// File: rtl/simon_decrypt_pkg.sv
// simon_decrypt_pkg: Simon parameter tables, z sequences and FSM state encoding
package simon_decrypt_pkg;
    localparam int N_DEF = 16;
    localparam int M_DEF = 4;
    // z sequences written in published order; z_j[i] is bit [61-i]
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;
    // round count T(n,m); 0 marks an unsupported pair
    function automatic int rounds(input int n, input int m);
        case (n * 10 + m)
            164: return 32;
            243, 244: return 36;
            323: return 42;
            324: return 44;
            482: return 52;
            483: return 54;
            642: return 68;
            643: return 69;
            644: return 72;
            default: return 0;
        endcase
    endfunction
    // which z sequence the (n,m) pair uses
    function automatic int z_index(input int n, input int m);
        case (n * 10 + m)
            244: return 1;
            323, 482, 642: return 2;
            324, 483, 643: return 3;
            644: return 4;
            default: return 0;
        endcase
    endfunction
    function automatic logic [61:0] z_seq(input int j);
        return j == 0 ? Z0 : j == 1 ? Z1 : j == 2 ? Z2 : j == 3 ? Z3 : Z4;
    endfunction
endpackage

// File: rtl/simon_inv_round.sv
// simon_inv_round: one combinational Simon inverse round, {a,b},k -> {b, a^f(b)^k}
module simon_inv_round #(
    parameter int N = 16
) (
    input  logic [2*N-1:0] x,
    input  logic [N-1:0]   k,
    output logic [2*N-1:0] next
);
    logic [N-1:0] a, b, f;
    assign a = x[2*N-1:N];
    assign b = x[N-1:0];
    assign f = ({b[N-2:0], b[N-1]} & {b[N-9:0], b[N-1:N-8]}) ^ {b[N-3:0], b[N-1:N-2]};
    assign next = {b, a ^ f ^ k};
endmodule

// File: rtl/simon_decrypt.sv
// simon_decrypt: iterative Simon decryption, forward key expansion then one inverse round per clock
module simon_decrypt
    import simon_decrypt_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [2*N-1:0] ciphertext,
    input  logic [N*M-1:0] key,
    output logic [2*N-1:0] plaintext,
    output logic           done
);
    localparam int T = rounds(N, M);
    localparam int AW = $clog2(T);
    localparam logic [61:0] Z = z_seq(z_index(N, M));
    if (T == 0) begin : g_bad_pair
        $error("simon_decrypt: unsupported (N, M) pair");
    end
    state_t         state, state_next;
    logic [7:0]     cnt;
    logic [2*N-1:0] x, x_next;
    logic [N-1:0]   rk [T];
    logic [N-1:0]   w1, wm, wk, tmp, rk_new;
    logic [5:0]     zi;
    logic           start, last;
    assign start = en && (state == IDLE || state == DONE);
    assign last = cnt == 8'(T - 1);
    assign w1 = rk[AW'(cnt - 8'd1)];
    assign wm = rk[AW'(cnt - 8'(M))];
    assign wk = rk[AW'(cnt)];
    simon_inv_round #(.N(N)) u_round (.x(x), .k(wk), .next(x_next));
    // next round key from the words at cnt-1, cnt-3 (four-word keys only) and cnt-m
    always_comb begin
        tmp = {w1[2:0], w1[N-1:3]} ^ (M == 4 ? rk[AW'(cnt - 8'd3)] : '0);
        tmp = tmp ^ {tmp[0], tmp[N-1:1]};
        zi = 6'((cnt - 8'(M)) % 8'd62);
        rk_new = ~wm ^ tmp ^ N'(Z[6'd61 - zi]) ^ N'(3);
    end
    // state sequencing; a start from IDLE/DONE always wins
    always_comb begin
        state_next = state;
        if (start) state_next = EXPAND;
        else if (state == EXPAND && last) state_next = DECRYPT;
        else if (state == DECRYPT && cnt == 8'd0) state_next = DONE;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // counter, working block and result; done follows entry into DONE by one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            x <= '0;
            plaintext <= '0;
            done <= 1'b0;
        end else begin
            done <= state == DONE && !start;
            if (start) begin
                cnt <= 8'(M);
                x <= ciphertext;
                plaintext <= '0;
            end else if (state == EXPAND) begin
                cnt <= last ? cnt : cnt + 8'd1;
            end else if (state == DECRYPT) begin
                x <= x_next;
                if (cnt == 8'd0) plaintext <= x_next;
                else cnt <= cnt - 8'd1;
            end
        end
    end
    // round-key RAM, unreset: master key words on start, one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (start) for (int i = 0; i < M; i++) rk[AW'(i)] <= key[i*N +: N];
        else if (state == EXPAND) rk[AW'(cnt)] <= rk_new;
    end
endmodule
